// File: rtl/input_fm_pkg.sv
// Shared definitions for the input_fm tile loader: FSM encoding and width helpers.
package input_fm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAN = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FULL  = 3'd4
  } fm_state_e;

  // Counter width for a bound n: $clog2(n), never less than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bank_capacity(input int tm, input int tr, input int tc, input int x);
    return (tm / x) * tr * tc;
  endfunction

  localparam int DEF_TM = 16;
  localparam int DEF_TR = 64;
  localparam int DEF_TC = 16;
  localparam int DEF_X  = 4;

  localparam int CW_C = cw(DEF_TC);
  localparam int CW_R = cw(DEF_TR);
  localparam int CW_M = cw(DEF_TM);
  localparam int CW_X = cw(DEF_X);
  localparam int BANK_CAPACITY = bank_capacity(DEF_TM, DEF_TR, DEF_TC, DEF_X);

endpackage

// File: rtl/fm_tile_scan.sv
// Nested col/row/channel scan counters for one tile; bank_sel follows channel mod X.
module fm_tile_scan
  import input_fm_pkg::*;
#(
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16,
  parameter int X  = 4,
  localparam int CWC = cw(Tc),
  localparam int CWR = cw(Tr),
  localparam int CWM = cw(Tm),
  localparam int CWX = cw(X)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clean,
  input  logic           step,
  output logic [CWX-1:0] bank_sel,
  output logic           last
);

  localparam logic [CWC-1:0] C_LAST = CWC'(Tc - 1);
  localparam logic [CWR-1:0] R_LAST = CWR'(Tr - 1);
  localparam logic [CWM-1:0] M_LAST = CWM'(Tm - 1);
  localparam logic [CWX-1:0] X_LAST = CWX'(X - 1);
  localparam logic [CWC-1:0] C_ONE  = CWC'(1);
  localparam logic [CWR-1:0] R_ONE  = CWR'(1);
  localparam logic [CWM-1:0] M_ONE  = CWM'(1);
  localparam logic [CWX-1:0] X_ONE  = CWX'(1);

  logic [CWC-1:0] c_q, c_d;
  logic [CWR-1:0] r_q, r_d;
  logic [CWM-1:0] ch_q, ch_d;
  logic [CWX-1:0] bank_q, bank_d;

  always_comb begin
    c_d    = c_q;
    r_d    = r_q;
    ch_d   = ch_q;
    bank_d = bank_q;
    if (clean) begin
      c_d    = '0;
      r_d    = '0;
      ch_d   = '0;
      bank_d = '0;
    end else if (step) begin
      if (c_q == C_LAST) begin
        c_d = '0;
        if (r_q == R_LAST) begin
          r_d    = '0;
          ch_d   = (ch_q == M_LAST) ? '0 : ch_q + M_ONE;
          bank_d = (bank_q == X_LAST) ? '0 : bank_q + X_ONE;
        end else begin
          r_d = r_q + R_ONE;
        end
      end else begin
        c_d = c_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q    <= '0;
      r_q    <= '0;
      ch_q   <= '0;
      bank_q <= '0;
    end else begin
      c_q    <= c_d;
      r_q    <= r_d;
      ch_q   <= ch_d;
      bank_q <= bank_d;
    end
  end

  assign bank_sel = bank_q;
  assign last     = (c_q == C_LAST) && (r_q == R_LAST) && (ch_q == M_LAST);

endmodule

// File: rtl/input_fm_load_ctrl.sv
// Loads one channel-major input_fm tile into X banks, steering each word to bank (ch mod X).
// Handshake: a word transfers on any rising edge where in_valid & in_ready; in_ready is high only in LOAD.
module input_fm_load_ctrl
  import input_fm_pkg::*;
#(
  parameter int DW = 32,
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16,
  parameter int X  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] wr_data,
  output logic [X-1:0]  wr_ena,
  output logic          conv_tile_clean,
  output logic          tile_ready,
  input  logic          tile_consumed,
  output fm_state_e     state_dbg
);

  fm_state_e state_q, state_d;
  logic [cw(X)-1:0] bank_sel;
  logic scan_last;
  logic fire;

  fm_tile_scan #(.Tm(Tm), .Tr(Tr), .Tc(Tc), .X(X)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .clean    (conv_tile_clean),
    .step     (fire),
    .bank_sel (bank_sel),
    .last     (scan_last)
  );

  always_comb begin
    state_d         = state_q;
    in_ready        = 1'b0;
    conv_tile_clean = 1'b0;
    tile_ready      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAN;
      end
      ST_CLEAN: begin
        conv_tile_clean = 1'b1;
        state_d         = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && scan_last) state_d = ST_DRAIN;
      end
      // One cycle for the bank input register and RAM write to settle.
      ST_DRAIN: begin
        state_d = ST_FULL;
      end
      ST_FULL: begin
        tile_ready = 1'b1;
        if (tile_consumed) state_d = start ? ST_CLEAN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  assign fire = in_valid & in_ready;

  always_comb begin
    wr_ena = '0;
    if (fire) wr_ena[bank_sel] = 1'b1;
  end

  assign wr_data   = in_data;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_input_fm_load_ctrl.sv
// Bench for input_fm_load_ctrl: small 4x2x2/X=2 tile with directed vectors plus one default-size tile.
module tb_input_fm_load_ctrl;
  import input_fm_pkg::*;

  localparam int W = 34;  // {wr_ena[1:0], wr_data[31:0]}

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // small DUT
  logic        start, in_valid, tile_consumed;
  logic [31:0] in_data;
  logic        busy, in_ready, conv_tile_clean, tile_ready;
  logic [31:0] wr_data;
  logic [1:0]  wr_ena;
  fm_state_e   state_dbg;

  input_fm_load_ctrl #(.DW(32), .Tm(4), .Tr(2), .Tc(2), .X(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_data(wr_data), .wr_ena(wr_ena), .conv_tile_clean(conv_tile_clean),
    .tile_ready(tile_ready), .tile_consumed(tile_consumed), .state_dbg(state_dbg)
  );

  // default-size DUT
  logic        b_start, b_valid, b_consumed;
  logic [31:0] b_data;
  logic        b_busy, b_ready, b_clean, b_tile_ready;
  logic [31:0] b_wr_data;
  logic [3:0]  b_wr_ena;
  fm_state_e   b_state;

  input_fm_load_ctrl dut_big (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .wr_data(b_wr_data), .wr_ena(b_wr_ena), .conv_tile_clean(b_clean),
    .tile_ready(b_tile_ready), .tile_consumed(b_consumed), .state_dbg(b_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // vector table: per stream word, the bank enable it must land on
  typedef struct {
    logic [31:0] data;
    logic [1:0]  exp_ena;
  } vec_t;
  vec_t vec[16];
  logic [1:0] ena_tbl [16] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int fire_cnt = 0;

  always @(negedge clk) begin
    if (wr_ena !== 2'b00) begin
      fire_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {wr_ena, wr_data}, '0);
      end else begin
        check("write", {wr_ena, wr_data}, exp_q.pop_front());
      end
    end
  end

  // default-size monitor: 16*64 = 1024 words per channel, channel ch -> bank ch%4
  int big_k = 0;
  int big_bad = 0;
  int big_cnt [4] = '{0, 0, 0, 0};
  always @(negedge clk) begin
    if (b_wr_ena !== 4'b0000) begin
      if (b_wr_ena !== (4'b0001 << ((big_k / 1024) % 4))) big_bad++;
      for (int b = 0; b < 4; b++) if (b_wr_ena[b]) big_cnt[b]++;
      big_k++;
    end
  end

  // drivers (all stimulus changes at posedge + 1)
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_tile(input string nm);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_clean"}, conv_tile_clean, 1'b1);
    check({nm, "_clean_ready"}, in_ready, 1'b0);
    check({nm, "_clean_busy"}, busy, 1'b1);
    tick();
    check({nm, "_load_ready"}, in_ready, 1'b1);
    check({nm, "_load_clean"}, conv_tile_clean, 1'b0);
  endtask

  task automatic stream(input string nm, input logic [31:0] base, input int first,
                        input int n, input bit toggle);
    int w = first;
    int guard = 0;
    bit ph = 1'b1;
    while (w < first + n && guard < 200) begin
      in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      in_data = base + vec[w].data;
      if (in_valid && in_ready) begin
        exp_q.push_back({vec[w].exp_ena, base + vec[w].data});
        w++;
      end
      guard++;
      tick();
    end
    in_valid = 1'b0;
    if (guard >= 200) check({nm, "_timeout"}, 1'b1, 1'b0);
  endtask

  task automatic finish_tile(input string nm);
    check({nm, "_drain_state"}, state_dbg, ST_DRAIN);
    check({nm, "_drain_tile_ready"}, tile_ready, 1'b0);
    tick();
    check({nm, "_full_tile_ready"}, tile_ready, 1'b1);
    check({nm, "_full_in_ready"}, in_ready, 1'b0);
    check({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vec[i].data    = i;
      vec[i].exp_ena = ena_tbl[i];
    end
    start = 0; in_valid = 0; in_data = 0; tile_consumed = 0;
    b_start = 0; b_valid = 0; b_data = 0; b_consumed = 0;

    // reset state
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_clean", conv_tile_clean, 1'b0);
    check("rst_tile_ready", tile_ready, 1'b0);
    check("rst_wr_ena", wr_ena, 2'b00);
    check("rst_state", state_dbg, ST_IDLE);
    #11 rst = 1'b1;
    tick();

    // 1: continuous stream
    start_tile("t1");
    stream("t1", 32'h1000, 0, 16, 1'b0);
    finish_tile("t1");
    check("t1_fires", fire_cnt, 16);

    // 3: start without tile_consumed is ignored in FULL
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      tick();
      check("t3_hold_full", state_dbg, ST_FULL);
      check("t3_hold_ready", tile_ready, 1'b1);
    end
    tile_consumed = 1'b1;
    start_tile("t3");
    tile_consumed = 1'b0;

    // 2: in_valid toggling on the back-to-back tile
    stream("t2", 32'h2000, 0, 16, 1'b1);
    finish_tile("t2");
    check("t2_fires", fire_cnt, 32);

    // 4: tile_consumed alone releases to IDLE
    tile_consumed = 1'b1;
    tick();
    tile_consumed = 1'b0;
    check("t4_idle", state_dbg, ST_IDLE);
    check("t4_busy", busy, 1'b0);
    check("t4_tile_ready", tile_ready, 1'b0);
    start_tile("t4");
    stream("t4a", 32'h3000, 0, 4, 1'b0);
    tile_consumed = 1'b1;
    tick();
    tile_consumed = 1'b0;
    check("t4_consumed_in_load", state_dbg, ST_LOAD);
    stream("t4b", 32'h3000, 4, 3, 1'b0);

    // 5: async reset after word 6, no clock edge involved
    in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_in_ready", in_ready, 1'b0);
    check("t5_wr_ena", wr_ena, 2'b00);
    check("t5_state", state_dbg, ST_IDLE);
    check("t5_sb_empty", exp_q.size(), 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start_tile("t5");
    stream("t5", 32'h4000, 0, 16, 1'b0);
    finish_tile("t5");
    check("t5_fires", fire_cnt, 7 + 48);

    // 6: default parameters, one full tile
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("t6_clean", b_clean, 1'b1);
    b_valid = 1'b1;
    begin
      int guard = 0;
      while (!b_tile_ready && guard < 20000) begin
        tick();
        guard++;
      end
      if (guard >= 20000) check("t6_timeout", 1'b1, 1'b0);
    end
    b_valid = 1'b0;
    check("t6_total", big_k, 16384);
    for (int b = 0; b < 4; b++) check($sformatf("t6_bank%0d", b), big_cnt[b], 4096);
    check("t6_route", big_bad, 0);
    check("t6_tile_ready", b_tile_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
